// File: rtl/interp_normalizer_if.sv
// interp_normalizer_if: stereo sample handshake between interpolator, normalizer and output stage.
interface interp_normalizer_if #(
  parameter int DIN_W  = 34,
  parameter int DIV_W  = 11,
  parameter int DOUT_W = 24
);
  logic              din_valid;
  logic [DIN_W-1:0]  l_data_in;
  logic [DIN_W-1:0]  r_data_in;
  logic [DIV_W-1:0]  divisor;
  logic              dout_valid;
  logic [DOUT_W-1:0] l_data_out;
  logic [DOUT_W-1:0] r_data_out;
  logic              busy;
  logic              overrun;
  logic              div_zero;
  modport master (
    output din_valid, l_data_in, r_data_in, divisor,
    input  dout_valid, l_data_out, r_data_out, busy, overrun, div_zero
  );
  modport slave (
    input  din_valid, l_data_in, r_data_in, divisor,
    output dout_valid, l_data_out, r_data_out, busy, overrun, div_zero
  );
endinterface

// File: rtl/interp_normalizer.sv
// interp_normalizer: divides stereo interpolation sums by the sub-sample span with one shared
// restoring divider (L then R), saturating each result to DOUT_W signed.
module interp_normalizer #(
  parameter int DIN_W     = 34,
  parameter int DIV_W     = 11,
  parameter int DOUT_W    = 24,
  parameter int PRE_SHIFT = 2
) (
  input logic clk,
  input logic reset,
  interp_normalizer_if.slave bus
);
  localparam int N  = DIN_W + PRE_SHIFT;
  localparam int CW = $clog2(N);
  localparam logic [N-1:0] Q_MAX = N'((64'd1 << (DOUT_W - 1)) - 64'd1);
  typedef enum logic [2:0] {IDLE, DIV_L, SAT_L, DIV_R, SAT_R, OUT} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_num;
  logic [DIV_W:0]    r_rem;
  logic [DIV_W-1:0]  r_div;
  logic [DIN_W-1:0]  r_r_in;
  logic              r_l_neg, r_r_neg, r_ovr, r_dz;
  logic [DOUT_W-1:0] r_l_res, r_l_out, r_r_out;
  logic [DIV_W+1:0]  w_sh, w_dif;
  logic              w_ge, w_busy, w_dout_valid;
  function automatic logic [N-1:0] numer(input logic [DIN_W-1:0] x);
    logic [DIN_W:0] mag;
    mag = x[DIN_W-1] ? -{x[DIN_W-1], x} : {x[DIN_W-1], x};
    return N'({mag, {PRE_SHIFT{1'b0}}});
  endfunction
  // Zero quotient (or a zero divisor) always yields +0, never a negative zero.
  function automatic logic [DOUT_W-1:0] sat(input logic [N-1:0] q, input logic neg, input logic dz);
    return (dz || q == '0) ? '0 :
           !neg ? (q > Q_MAX ? DOUT_W'(Q_MAX) : q[DOUT_W-1:0]) :
           (q > Q_MAX + N'(1) ? {1'b1, {(DOUT_W-1){1'b0}}} : -q[DOUT_W-1:0]);
  endfunction
  assign w_sh  = {r_rem, r_num[N-1]};
  assign w_ge  = w_sh >= {2'b00, r_div};
  assign w_dif = w_sh - {2'b00, r_div};
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.din_valid ? DIV_L : IDLE;
      DIV_L:   w_next = r_cnt == CW'(N - 1) ? SAT_L : DIV_L;
      SAT_L:   w_next = DIV_R;
      DIV_R:   w_next = r_cnt == CW'(N - 1) ? SAT_R : DIV_R;
      SAT_R:   w_next = OUT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_busy       = r_state != IDLE;
    w_dout_valid = r_state == OUT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_num   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_r_in  <= '0;
      r_l_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_ovr   <= 1'b0;
      r_dz    <= 1'b0;
      r_l_res <= '0;
      r_l_out <= '0;
      r_r_out <= '0;
    end else begin
      if (bus.din_valid && r_state != IDLE) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (bus.din_valid) begin
          r_num   <= numer(bus.l_data_in);
          r_rem   <= '0;
          r_cnt   <= '0;
          r_div   <= bus.divisor;
          r_r_in  <= bus.r_data_in;
          r_l_neg <= bus.l_data_in[DIN_W-1];
          r_r_neg <= bus.r_data_in[DIN_W-1];
          r_dz    <= r_dz | (bus.divisor == '0);
        end
        DIV_L, DIV_R: begin
          r_num <= {r_num[N-2:0], w_ge};
          r_rem <= (DIV_W + 1)'(w_ge ? w_dif : w_sh);
          r_cnt <= r_cnt + 1'b1;
        end
        SAT_L: begin
          r_l_res <= sat(r_num, r_l_neg, r_div == '0);
          r_num   <= numer(r_r_in);
          r_rem   <= '0;
          r_cnt   <= '0;
        end
        SAT_R: begin
          r_l_out <= r_l_res;
          r_r_out <= sat(r_num, r_r_neg, r_div == '0);
        end
        default: ;
      endcase
    end
  end
  assign bus.dout_valid = w_dout_valid;
  assign bus.busy       = w_busy;
  assign bus.l_data_out = r_l_out;
  assign bus.r_data_out = r_r_out;
  assign bus.overrun    = r_ovr;
  assign bus.div_zero   = r_dz;
endmodule

// File: tb/tb_interp_normalizer.sv
// tb_interp_normalizer: directed frames plus a reference-model sweep for interp_normalizer.
module tb_interp_normalizer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  interp_normalizer_if bus ();
  interp_normalizer dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [33:0] l, input logic [33:0] r, input logic [10:0] d);
    bus.l_data_in = l;
    bus.r_data_in = r;
    bus.divisor   = d;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask
  // Called just after the capture edge T; iteration c observes what edge T+c samples.
  task automatic run_frame(input string tag, input int ncyc, input int inj_a, input int inj_b,
                           input logic [23:0] el, input logic [23:0] er);
    int pulses = 0;
    int at = -1;
    int busy_bad = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == inj_a || c == inj_b) begin
        bus.l_data_in = 34'd999999;
        bus.r_data_in = 34'd777;
        bus.divisor   = 11'd5;
        bus.din_valid = 1'b1;
      end
      if (bus.dout_valid === 1'b1) begin
        pulses++;
        at = c;
      end
      if (bus.busy !== (c <= 75)) busy_bad++;
      tick();
      bus.din_valid = 1'b0;
    end
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_latency"}, 64'(at), 64'd75);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_l"}, 64'(bus.l_data_out), 64'(el));
    check({tag, "_r"}, 64'(bus.r_data_out), 64'(er));
  endtask
  function automatic logic [23:0] model(input longint s, input longint d);
    longint q = (s * 4) / d;
    if (q > 64'sd8388607) q = 64'sd8388607;
    else if (q < -64'sd8388608) q = -64'sd8388608;
    return q[23:0];
  endfunction
  initial begin
    longint vl, vr, sl, sr;
    int d, stray;
    bus.din_valid = 1'b0;
    bus.l_data_in = '0;
    bus.r_data_in = '0;
    bus.divisor   = '0;
    bus.din_valid = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.din_valid = 1'b0;
    check("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_l", 64'(bus.l_data_out), 64'd0);
    check("rst_r", 64'(bus.r_data_out), 64'd0);
    check("rst_overrun", 64'(bus.overrun), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);
    start(34'd128000, -34'sd128000, 11'd512);
    run_frame("t1", 80, -1, -1, 24'h0003E8, 24'hFFFC18);
    check("t1_overrun", 64'(bus.overrun), 64'd0);
    start(34'h1_FFFF_FFFF, 34'h2_0000_0000, 11'd1);
    run_frame("t2", 80, -1, -1, 24'h7FFFFF, 24'h800000);
    check("t2_overrun", 64'(bus.overrun), 64'd0);
    check("t2_div_zero", 64'(bus.div_zero), 64'd0);
    start(34'd1000, -34'sd7, 11'd0);
    run_frame("t3", 80, -1, -1, 24'h000000, 24'h000000);
    check("t3_div_zero", 64'(bus.div_zero), 64'd1);
    check("t3_overrun", 64'(bus.overrun), 64'd0);
    start(34'd4096, 34'd0, 11'd16);
    run_frame("t4a", 75, 10, 75, 24'h000400, 24'h000000);
    check("t4_overrun", 64'(bus.overrun), 64'd1);
    start(-34'sd4096, 34'd160, 11'd16);
    run_frame("t4b", 80, -1, -1, 24'hFFFC00, 24'h000028);
    start(34'd4096, 34'd0, 11'd16);
    repeat (39) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_l", 64'(bus.l_data_out), 64'd0);
    check("t5_r", 64'(bus.r_data_out), 64'd0);
    check("t5_overrun", 64'(bus.overrun), 64'd0);
    check("t5_div_zero", 64'(bus.div_zero), 64'd0);
    stray = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.dout_valid !== 1'b0) stray++;
      tick();
    end
    check("t5_no_dout", 64'(stray), 64'd0);
    start(34'd100, -34'sd100, 11'd3);
    run_frame("t5b", 80, -1, -1, 24'd133, 24'hFFFF7B);
    for (int f = 0; f < 100; f++) begin
      vl = {$urandom, $urandom};
      vr = {$urandom, $urandom};
      sl = vl >>> (30 + $urandom_range(0, 25));
      sr = vr >>> (30 + $urandom_range(0, 25));
      d  = $urandom_range(1, 2047);
      start(sl[33:0], sr[33:0], 11'(d));
      run_frame($sformatf("t6_%0d", f), 80, -1, -1, model(sl, 64'(d)), model(sr, 64'(d)));
      repeat (431) tick();
    end
    check("t6_overrun", 64'(bus.overrun), 64'd0);
    check("t6_div_zero", 64'(bus.div_zero), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
